ineq_sweep_checker: RTL and testbench
=====================================

// Module: ineq_sweep_checker
// PURPOSE
//  Hardware self-check engine for the 4-bit inequality block: drives every input code 0..2^IN_W-1
//  into the DUT and samples the DUT's 3-bit output after a settle delay.
//  Compares each sample against an expected-value table and reports pass/fail, a mismatch count
//  and the first failing vector. Sits beside the DUT in FPGA builds and replaces the printed
//  per-vector checks with an on-chip result.
// PARAMETERS
//  IN_W        4                    DUT input width; the sweep covers 2**IN_W codes
//  OUT_W       3                    DUT output width
//  SETTLE_CYC  2                    cycles between driving dut_in and sampling dut_out (>=1)
//  EXP_TABLE   INEQ_EXPECT (pkg)    (2**IN_W)*OUT_W bits; entry k = EXP_TABLE[k*OUT_W +: OUT_W]
// PORTS
//  clk          in   1                 single clock, rising edge
//  reset        in   1                 synchronous, active-high
//  start        in   1                 one-cycle request to begin a sweep
//  abort        in   1                 stop the current sweep, go to DONE with pass=0
//  dut_out      in   OUT_W             DUT output (combinational from dut_in)
//  dut_in       out  IN_W              vector currently driven to the DUT
//  busy         out  1                 sweep in progress
//  done         out  1                 level; high from the end of a sweep until the next start
//  pass         out  1                 valid while done; 1 = all vectors matched and no abort
//  mismatch     out  1                 one-cycle pulse on each failing sample
//  fail_count   out  IN_W+1            number of mismatches in this sweep; saturates at 2**IN_W
//  first_fail   out  IN_W              dut_in of the first mismatch
//  first_valid  out  1                 first_fail holds a captured vector
// BEHAVIOUR
//  - Reset values (reset has priority over everything, including mid-sweep): state=IDLE,
//    dut_in=0, busy=0, done=0, pass=0, mismatch=0, fail_count=0, first_fail=0, first_valid=0.
//  - States: IDLE -> SETTLE -> SAMPLE -> (SETTLE | DONE); DONE -> SETTLE on start.
//  - IDLE/DONE + start: dut_in<=0, fail_count<=0, first_valid<=0, first_fail<=0, done<=0,
//    pass<=0, busy<=1, settle counter<=SETTLE_CYC-1, next state SETTLE.
//  - start while busy is ignored.
//  - SETTLE: decrement the counter each cycle; go to SAMPLE when it reaches 0.
//    Sample timing: dut_out is sampled exactly SETTLE_CYC cycles after dut_in changes.
//  - SAMPLE, comparing dut_out with EXP_TABLE entry for dut_in:
//    - On mismatch: pulse mismatch for one cycle and increment fail_count, saturating.
//      If first_valid=0, set first_fail<=dut_in and first_valid<=1.
//    - If dut_in == 2**IN_W-1: go to DONE, busy<=0, done<=1,
//      pass<=(no mismatch this sweep, including this sample).
//    - Otherwise: dut_in<=dut_in+1, reload the settle counter, go to SETTLE.
//  - The index never wraps within a sweep; there is no index increment after the last vector.
//  - Sweep latency from start to done: (2**IN_W)*(SETTLE_CYC+1)+1 cycles.
//    With the defaults this is 49.
//  - abort while busy: next cycle state=DONE, busy=0, done=1, pass=0.
//    fail_count, first_fail and first_valid keep their values; dut_in holds.
//    abort in IDLE/DONE has no effect. abort and start in the same cycle while busy: abort wins.
//    start and abort in the same cycle in IDLE/DONE: start wins.
//  - Results (pass, fail_count, first_*) stay stable in DONE until the next start or reset.
// STRUCTURE
//  - Package ineq_check_pkg holds: state encoding (IDLE, SETTLE, SAMPLE, DONE),
//    INEQ_EXPECT constant, default widths.
//  - INEQ_EXPECT is the golden inequality truth table; entry 5 = 3'b001.
//  - One natural sub-module: ineq_settle_timer, a loadable down-counter with zero flag.
//  - Compare, capture and FSM logic stay in the top module.
// TESTING
//  - Golden DUT model, reset, then start: busy=1 the next cycle; dut_in steps 0..15;
//    done=1 and pass=1 after 49 cycles; fail_count=0; first_valid=0.
//  - DUT output forced to 3'b000 when dut_in=5, else golden:
//    mismatch pulses once at the 5th-index sample; done with pass=0;
//    fail_count=1; first_fail=5; first_valid=1.
//  - DUT output always inverted: fail_count=16 (saturated, no overflow); first_fail=0; pass=0.
//  - abort asserted while dut_in=7: next cycle done=1, pass=0, busy=0, dut_in=7;
//    a second start then restarts from dut_in=0 with counters cleared.
//  - reset asserted mid-sweep (dut_in=9): every output returns to its reset value
//    on the next edge; start pulses during busy produce no restart (dut_in keeps incrementing).
//  - SETTLE_CYC=1 build: done after 33 cycles; a DUT whose output lags dut_in by 2 cycles
//    reports fail_count>0.

Source files
------------

// File: rtl/ineq_check_pkg.sv
// Shared types and constants for the inequality-block sweep checker.
// The golden table encodes {a>b, a<b, a==b} with a = code[3:2], b = code[1:0].
package ineq_check_pkg;

    localparam int DEF_IN_W       = 4;
    localparam int DEF_OUT_W      = 3;
    localparam int DEF_SETTLE_CYC = 2;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    // Entries listed from code 15 down to code 0.
    localparam logic [(2**DEF_IN_W)*DEF_OUT_W-1:0] INEQ_EXPECT = {
        3'b001, 3'b100, 3'b100, 3'b100,
        3'b010, 3'b001, 3'b100, 3'b100,
        3'b010, 3'b010, 3'b001, 3'b100,
        3'b010, 3'b010, 3'b010, 3'b001
    };

endpackage

// File: rtl/ineq_settle_timer.sv
// Loadable down-counter with a zero flag; paces the delay between driving
// a vector and capturing the DUT response.
module ineq_settle_timer #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic [W-1:0] count,
    output logic         zero
);

    // Counter register: load has priority over decrement; never underflows.
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= {W{1'b0}};
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != {W{1'b0}})) begin
            count <= count - W'(1);
        end
    end

    assign zero = (count == {W{1'b0}});

endmodule

// File: rtl/ineq_sweep_checker.sv
// On-chip self-check engine: sweeps every input code into the inequality
// block, compares each settled response with the golden table and keeps a result.
module ineq_sweep_checker
    import ineq_check_pkg::*;
#(
    parameter int IN_W       = DEF_IN_W,
    parameter int OUT_W      = DEF_OUT_W,
    parameter int SETTLE_CYC = DEF_SETTLE_CYC,
    parameter logic [(2**IN_W)*OUT_W-1:0] EXP_TABLE = INEQ_EXPECT
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic            abort,
    input  logic [OUT_W-1:0] dut_out,
    output logic [IN_W-1:0] dut_in,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic            mismatch,
    output logic [IN_W:0]   fail_count,
    output logic [IN_W-1:0] first_fail,
    output logic            first_valid
);

    localparam int CNT_W = $clog2(SETTLE_CYC + 1);
    localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYC - 1);
    localparam logic [IN_W:0]    FAIL_MAX    = {1'b1, {IN_W{1'b0}}};
    localparam logic [IN_W-1:0]  LAST_CODE   = {IN_W{1'b1}};

    state_t            state;
    state_t            state_next;
    logic              tmr_load;
    logic              tmr_dec;
    logic              tmr_zero;
    logic [CNT_W-1:0]  tmr_count;
    logic              sweep_start;
    logic              do_abort;
    logic              do_capture;
    logic              do_sample;
    logic [OUT_W-1:0]  sample;
    logic [OUT_W-1:0]  exp_val;
    logic              sample_bad;
    logic              last_code;

    ineq_settle_timer #(.W(CNT_W)) u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (tmr_load),
        .load_val (SETTLE_LOAD),
        .dec      (tmr_dec),
        .count    (tmr_count),
        .zero     (tmr_zero)
    );

    assign exp_val    = EXP_TABLE[int'(dut_in) * OUT_W +: OUT_W];
    assign sample_bad = (sample != exp_val);
    assign last_code  = (dut_in == LAST_CODE);

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and per-cycle control strobes; abort outranks start and sampling while busy.
    always_comb begin
        state_next  = state;
        tmr_load    = 1'b0;
        tmr_dec     = 1'b0;
        sweep_start = 1'b0;
        do_abort    = 1'b0;
        do_capture  = 1'b0;
        do_sample   = 1'b0;
        case (state)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_next  = ST_SETTLE;
                    tmr_load    = 1'b1;
                    sweep_start = 1'b1;
                end else begin
                    state_next = state;
                end
            end
            ST_SETTLE: begin
                if (abort) begin
                    state_next = ST_DONE;
                    do_abort   = 1'b1;
                end else if (tmr_zero) begin
                    state_next = ST_SAMPLE;
                    do_capture = 1'b1;
                end else begin
                    tmr_dec = 1'b1;
                end
            end
            ST_SAMPLE: begin
                if (abort) begin
                    state_next = ST_DONE;
                    do_abort   = 1'b1;
                end else if (last_code) begin
                    state_next = ST_DONE;
                    do_sample  = 1'b1;
                end else begin
                    state_next = ST_SETTLE;
                    tmr_load   = 1'b1;
                    do_sample  = 1'b1;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Vector index, response capture, compare bookkeeping and result registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            dut_in      <= {IN_W{1'b0}};
            busy        <= 1'b0;
            done        <= 1'b0;
            pass        <= 1'b0;
            mismatch    <= 1'b0;
            fail_count  <= {(IN_W+1){1'b0}};
            first_fail  <= {IN_W{1'b0}};
            first_valid <= 1'b0;
            sample      <= {OUT_W{1'b0}};
        end else begin
            mismatch <= 1'b0;
            if (sweep_start) begin
                dut_in      <= {IN_W{1'b0}};
                fail_count  <= {(IN_W+1){1'b0}};
                first_fail  <= {IN_W{1'b0}};
                first_valid <= 1'b0;
                done        <= 1'b0;
                pass        <= 1'b0;
                busy        <= 1'b1;
            end else if (do_abort) begin
                busy <= 1'b0;
                done <= 1'b1;
                pass <= 1'b0;
            end else if (do_capture) begin
                sample <= dut_out;
            end else if (do_sample) begin
                if (sample_bad) begin
                    mismatch <= 1'b1;
                    if (fail_count != FAIL_MAX) begin
                        fail_count <= fail_count + (IN_W+1)'(1);
                    end
                    if (!first_valid) begin
                        first_fail  <= dut_in;
                        first_valid <= 1'b1;
                    end
                end
                // The last code ends the sweep without advancing the index.
                if (last_code) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                    pass <= (fail_count == {(IN_W+1){1'b0}}) && !sample_bad;
                end else begin
                    dut_in <= dut_in + IN_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_ineq_sweep_checker.sv
// Directed bench for ineq_sweep_checker: golden, faulty and lagging DUT models
// around a default build and a SETTLE_CYC=1 build.
module tb_ineq_sweep_checker;

    logic       clk = 1'b0;
    logic       reset, start, abort, start2, abort2;
    logic [2:0] dut_out, dut_out2;
    logic [3:0] dut_in, dut_in2, first_fail, first_fail2, d1, d2;
    logic       busy, done, pass, mismatch, first_valid;
    logic       busy2, done2, pass2, mismatch2, first_valid2;
    logic [4:0] fail_count, fail_count2;
    int         mode = 0;
    int         lag_mode = 0;
    int         n_assert = 0;
    int         n_fail = 0;
    int         cyc, pulses;

    always #5 clk = ~clk;

    ineq_sweep_checker dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort), .dut_out(dut_out),
        .dut_in(dut_in), .busy(busy), .done(done), .pass(pass), .mismatch(mismatch),
        .fail_count(fail_count), .first_fail(first_fail), .first_valid(first_valid)
    );

    ineq_sweep_checker #(.SETTLE_CYC(1)) dut2 (
        .clk(clk), .reset(reset), .start(start2), .abort(abort2), .dut_out(dut_out2),
        .dut_in(dut_in2), .busy(busy2), .done(done2), .pass(pass2), .mismatch(mismatch2),
        .fail_count(fail_count2), .first_fail(first_fail2), .first_valid(first_valid2)
    );

    function automatic logic [2:0] golden(input logic [3:0] v);
        logic [1:0] a, b;
        a = v[3:2];
        b = v[1:0];
        return {a > b, a < b, a == b};
    endfunction

    always_comb begin
        case (mode)
            1:       dut_out = (dut_in == 4'd5) ? 3'b000 : golden(dut_in);
            2:       dut_out = ~golden(dut_in);
            default: dut_out = golden(dut_in);
        endcase
        dut_out2 = (lag_mode != 0) ? golden(d2) : golden(dut_in2);
    end

    always @(posedge clk) begin
        d1 <= dut_in2;
        d2 <= d1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, " dut_in"},      32'(dut_in), 32'd0);
        check({tag, " busy"},        32'(busy), 32'd0);
        check({tag, " done"},        32'(done), 32'd0);
        check({tag, " pass"},        32'(pass), 32'd0);
        check({tag, " mismatch"},    32'(mismatch), 32'd0);
        check({tag, " fail_count"},  32'(fail_count), 32'd0);
        check({tag, " first_fail"},  32'(first_fail), 32'd0);
        check({tag, " first_valid"}, 32'(first_valid), 32'd0);
    endtask

    // Start pulse on dut, then follow it to done; checks latency and index stepping.
    task automatic sweep(input string tag, output int c, output int p);
        logic [3:0] prev;
        int         step_err;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        c = 1;
        check({tag, " busy after start"}, 32'(busy), 32'd1);
        check({tag, " dut_in after start"}, 32'(dut_in), 32'd0);
        check({tag, " done cleared"}, 32'(done), 32'd0);
        prev = dut_in;
        p = 0;
        step_err = 0;
        while (!done && c < 200) begin
            @(negedge clk);
            c++;
            p += int'(mismatch);
            if (dut_in != prev && dut_in != prev + 4'd1) step_err++;
            prev = dut_in;
        end
        check({tag, " latency"}, 32'(c), 32'd49);
        check({tag, " index steps"}, 32'(step_err), 32'd0);
        check({tag, " final dut_in"}, 32'(dut_in), 32'd15);
        check({tag, " busy at end"}, 32'(busy), 32'd0);
    endtask

    task automatic sweep2(input string tag);
        int c;
        start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        c = 1;
        while (!done2 && c < 200) begin
            @(negedge clk);
            c++;
        end
        check({tag, " latency"}, 32'(c), 32'd33);
    endtask

    task automatic wait_code(input logic [3:0] v);
        int n = 0;
        while (dut_in != v && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("reach code", 32'(dut_in), 32'(v));
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; abort = 1'b0; start2 = 1'b0; abort2 = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        check_reset_vals("reset");

        // Golden DUT
        mode = 0;
        sweep("golden", cyc, pulses);
        check("golden pass", 32'(pass), 32'd1);
        check("golden done", 32'(done), 32'd1);
        check("golden fail_count", 32'(fail_count), 32'd0);
        check("golden first_valid", 32'(first_valid), 32'd0);
        check("golden pulses", 32'(pulses), 32'd0);

        // Output stuck at 000 for code 5
        mode = 1;
        sweep("code5", cyc, pulses);
        check("code5 pulses", 32'(pulses), 32'd1);
        check("code5 pass", 32'(pass), 32'd0);
        check("code5 fail_count", 32'(fail_count), 32'd1);
        check("code5 first_fail", 32'(first_fail), 32'd5);
        check("code5 first_valid", 32'(first_valid), 32'd1);

        // Every response inverted
        mode = 2;
        sweep("invert", cyc, pulses);
        check("invert fail_count", 32'(fail_count), 32'd16);
        check("invert first_fail", 32'(first_fail), 32'd0);
        check("invert pass", 32'(pass), 32'd0);
        check("invert pulses", 32'(pulses), 32'd16);

        // Abort at code 7 (start in the same cycle loses)
        mode = 1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_code(4'd7);
        abort = 1'b1; start = 1'b1;
        @(negedge clk);
        abort = 1'b0; start = 1'b0;
        check("abort done", 32'(done), 32'd1);
        check("abort pass", 32'(pass), 32'd0);
        check("abort busy", 32'(busy), 32'd0);
        check("abort dut_in", 32'(dut_in), 32'd7);
        check("abort fail_count", 32'(fail_count), 32'd1);
        check("abort first_fail", 32'(first_fail), 32'd5);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        @(negedge clk);
        check("abort in done ignored", 32'(done), 32'd1);
        check("done results stable", 32'(fail_count), 32'd1);
        check("done dut_in stable", 32'(dut_in), 32'd7);

        // Restart from DONE with start and abort together
        start = 1'b1; abort = 1'b1;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        check("restart busy", 32'(busy), 32'd1);
        check("restart dut_in", 32'(dut_in), 32'd0);
        check("restart fail_count", 32'(fail_count), 32'd0);
        check("restart first_valid", 32'(first_valid), 32'd0);
        check("restart done", 32'(done), 32'd0);

        // Start while busy must not restart
        wait_code(4'd3);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        check("no restart", 32'(dut_in >= 4'd4), 32'd1);

        // Reset mid-sweep
        wait_code(4'd9);
        check("pre-reset fail_count", 32'(fail_count), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check_reset_vals("mid reset");
        @(negedge clk);
        check("idle after reset", 32'(busy), 32'd0);

        // SETTLE_CYC=1 build: golden, then a DUT lagging by two cycles
        lag_mode = 0;
        sweep2("fast golden");
        check("fast golden pass", 32'(pass2), 32'd1);
        check("fast golden fail_count", 32'(fail_count2), 32'd0);
        lag_mode = 1;
        sweep2("fast lag");
        check("fast lag fails", 32'(fail_count2 > 5'd0), 32'd1);
        check("fast lag pass", 32'(pass2), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
